instr_fetch_unit: RTL

Initiator side of the instruction-memory read port. Drives the word address into the combinational instruction memory and captures the returned instruction word. Stores fetched words, each tagged with its PC, in a small prefetch FIFO. Presents them to decode over a valid/ready handshake, and accepts branch/jump redirects that flush in-flight fetches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: instruction width,
// sequential PC step, default reset vector and the prefetch entry layout.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetched instruction tagged with the address it came from.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO. Flush empties it in one edge and wins
// over any push/pop presented in the same cycle. A pop when empty and a
// push when full without a matching pop are ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  entry_t                   i_data,
  output entry_t                   o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rdPtr;
  logic [AW-1:0]   r_wrPtr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage array: written on an accepted push, never reset (contents are
  // only meaningful while counted).
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the combinational instruction memory from
// the fetch PC, buffers returned words with their PC in a prefetch FIFO and
// hands them to decode over valid/ready. Redirects flush the FIFO and reload
// the fetch PC.
// Build option: define FETCH_MISALIGN_CHECK_EN to halt fetch and raise
// misalign on a redirect to a non-word-aligned target; otherwise the low
// two target bits are cleared and misalign is tied low.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4,
  parameter int          PC_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    iaddr,
  input  logic [INSTR_W-1:0] idata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redir_valid,
  input  logic [PC_W-1:0]    redir_pc,
  output logic               misalign
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0] r_fetchPc;
  logic [PC_W-1:0] w_redirTarget;
  logic            w_halted;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [AW:0]     w_count;
  entry_t          w_wrEntry;
  entry_t          w_head;

  assign iaddr     = r_fetchPc;
  assign out_valid = ~w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  assign w_pop  = out_valid & out_ready;
  assign w_push = ~redir_valid & ~w_halted & (~w_full | w_pop);

  assign w_wrEntry.pc    = r_fetchPc;
  assign w_wrEntry.instr = idata;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_halted;

  assign w_redirTarget = redir_pc;
  assign w_halted      = r_halted;
  assign misalign      = r_halted;

  // A redirect to a misaligned target stops fetching until the next
  // redirect lands on a word boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (redir_valid) begin
      r_halted <= |redir_pc[1:0];
    end
  end
`else
  assign w_redirTarget = redir_pc & ~PC_W'(3);
  assign w_halted      = 1'b0;
  assign misalign      = 1'b0;
`endif

  // Fetch PC: redirect reloads it, an accepted push steps to the next word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetchPc <= PC_W'(RESET_PC);
    end else if (redir_valid) begin
      r_fetchPc <= w_redirTarget;
    end else if (w_push) begin
      r_fetchPc <= r_fetchPc + PC_W'(PC_INC);
    end
  end

  // Occupancy can never exceed the FIFO depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (w_count <= CNT_FULL);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redir_valid),
    .i_data  (w_wrEntry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
